// File: rtl/time_pkg.sv
// Shared types, digit limits and helpers for the BCD timekeeper.
// Imported by the counter datapath and by the time-setting front end.
// Contents: bcd_t, digit limits, num_dig(), bcd_valid().
package time_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Highest legal value of a units digit, and of a tens digit in a
  // sexagesimal field (seconds / minutes).
  localparam bcd_t DIG_MAX_LO = 4'd9;
  localparam bcd_t DIG_MAX_HI = 4'd5;

  // Modulus of the seconds and minutes fields.
  localparam int SEXA_MOD = 60;

  // Number of displayed digits: MM:SS or HH:MM:SS.
  function automatic int num_dig(input int hours_en);
    return (hours_en != 0) ? 6 : 4;
  endfunction

  // A two-digit BCD field is valid when both digits are decimal and the
  // field value is below its modulus. For mod-60 fields this enforces the
  // tens digit limit DIG_MAX_HI; for hours it enforces HH < HOUR_MAX.
  function automatic logic bcd_valid(input bcd_t tens, input bcd_t ones,
                                     input int modulus);
    return (ones <= DIG_MAX_LO) && (tens <= DIG_MAX_LO) &&
           ((int'(tens) * 10 + int'(ones)) < modulus);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MODULUS up/down counter, one per time field.
// Latency: value updates one cycle after en_i/load_i; co_o is combinational.
// Backpressure: none; load_i has priority over en_i.
// Ports: clk_i, rst_ni (async low), en_i step, dir_i (0 up / 1 down),
//        load_i + load_val_i {tens,ones}, val_o {tens,ones},
//        co_o carry (up at max) / borrow (down at zero), is_zero_o.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] val_o,
  output logic       co_o,
  output logic       is_zero_o
);

  localparam bcd_t MAX_TENS = bcd_t'((MODULUS - 1) / 10);
  localparam bcd_t MAX_ONES = bcd_t'((MODULUS - 1) % 10);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_max;

  assign at_max    = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign is_zero_o = (tens_q == '0) && (ones_q == '0);
  assign val_o     = {tens_q, ones_q};

  // Ripple into the next field in the same cycle as this field wraps.
  assign co_o = en_i && !load_i && (dir_i ? is_zero_o : at_max);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = load_val_i[7:4];
      ones_d = load_val_i[3:0];
    end else if (en_i) begin
      if (!dir_i) begin
        if (at_max) begin
          tens_d = '0;
          ones_d = '0;
        end else if (ones_q == DIG_MAX_LO) begin
          ones_d = '0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (is_zero_o) begin
          tens_d = MAX_TENS;
          ones_d = MAX_ONES;
        end else if (ones_q == '0) begin
          ones_d = DIG_MAX_LO;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/time_counter.sv
// BCD MM:SS / HH:MM:SS clock-or-timer advanced by an internal 1 s tick enable.
// Latency: time_bcd and all pulses are registered, one cycle after tick/load.
// Backpressure: none; load pre-empts a coincident tick, run=0 holds.
// Ports: clk, reset_n (async low), run, dir (0 up / 1 down), load + load_bcd;
//        time_bcd, sec_tick, wrap, zero_hit, load_err (one-cycle pulses).
module time_counter
  import time_pkg::*;
#(
  parameter int  CLK_HZ   = 100_000_000,
  parameter int  TICK_DIV = CLK_HZ,
  parameter int  HOURS_EN = 0,
  parameter int  HOUR_MAX = 24,
  localparam int NUM_DIG  = num_dig(HOURS_EN),
  localparam int TW       = 4 * NUM_DIG
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic          dir,
  input  logic          load,
  input  logic [TW-1:0] load_bcd,
  output logic [TW-1:0] time_bcd,
  output logic          sec_tick,
  output logic          wrap,
  output logic          zero_hit,
  output logic          load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick, step_en, load_ok, ms_ok, all_zero, top_co;
  logic [7:0]    sec_val, min_val;
  logic          sec_co, min_co, sec_zero, min_zero;
  logic          sec_tick_q, sec_tick_d;
  logic          wrap_q, wrap_d;
  logic          zero_hit_q, zero_hit_d;
  logic          load_err_q, load_err_d;

  // ---------------- prescaler ----------------
  assign tick = run && (presc_q == PW'(TICK_DIV - 1));

  // Any load (good or bad) or a pause restarts the second from zero.
  always_comb begin
    presc_d = '0;
    if (run && !load && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // A down tick at all-zero is swallowed entirely: no step, no pulses.
  assign step_en = tick && !load && !(dir && all_zero);

  // ---------------- field counters ----------------
  assign ms_ok = bcd_valid(load_bcd[15:12], load_bcd[11:8], SEXA_MOD) &&
                 bcd_valid(load_bcd[7:4],   load_bcd[3:0],  SEXA_MOD);

  bcd_mod_counter #(.MODULUS(SEXA_MOD)) u_sec (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .en_i       (step_en),
    .dir_i      (dir),
    .load_i     (load_ok),
    .load_val_i (load_bcd[7:0]),
    .val_o      (sec_val),
    .co_o       (sec_co),
    .is_zero_o  (sec_zero)
  );

  bcd_mod_counter #(.MODULUS(SEXA_MOD)) u_min (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .en_i       (sec_co),
    .dir_i      (dir),
    .load_i     (load_ok),
    .load_val_i (load_bcd[15:8]),
    .val_o      (min_val),
    .co_o       (min_co),
    .is_zero_o  (min_zero)
  );

  if (HOURS_EN != 0) begin : g_hours
    logic [7:0] hr_val;
    logic       hr_co, hr_zero;

    bcd_mod_counter #(.MODULUS(HOUR_MAX)) u_hr (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .en_i       (min_co),
      .dir_i      (dir),
      .load_i     (load_ok),
      .load_val_i (load_bcd[23:16]),
      .val_o      (hr_val),
      .co_o       (hr_co),
      .is_zero_o  (hr_zero)
    );

    assign time_bcd = {hr_val, min_val, sec_val};
    assign top_co   = hr_co;
    assign all_zero = hr_zero && min_zero && sec_zero;
    assign load_ok  = load && ms_ok &&
                      bcd_valid(load_bcd[23:20], load_bcd[19:16], HOUR_MAX);
  end else begin : g_no_hours
    assign time_bcd = {min_val, sec_val};
    assign top_co   = min_co;
    assign all_zero = min_zero && sec_zero;
    assign load_ok  = load && ms_ok;
  end

  // ---------------- event pulses ----------------
  always_comb begin
    sec_tick_d = step_en;
    wrap_d     = step_en && !dir && top_co;
    // Only a value of exactly one second can count down onto zero.
    zero_hit_d = step_en && dir && (time_bcd == TW'(1));
    load_err_d = load && !load_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      wrap_q     <= 1'b0;
      zero_hit_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      wrap_q     <= wrap_d;
      zero_hit_q <= zero_hit_d;
      load_err_q <= load_err_d;
    end
  end

  assign sec_tick = sec_tick_q;
  assign wrap     = wrap_q;
  assign zero_hit = zero_hit_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset_n, run, dir;
  logic        ld_a, ld_b, ld_c;
  logic [15:0] lbcd_a, t_a;
  logic [23:0] lbcd_b, lbcd_c, t_b, t_c;
  logic        st_a, wr_a, zh_a, le_a;
  logic        st_b, wr_b, zh_b, le_b;
  logic        st_c, wr_c, zh_c, le_c;

  always #5 clk = ~clk;

  time_counter #(.CLK_HZ(100), .TICK_DIV(TD), .HOURS_EN(0), .HOUR_MAX(24)) u_a (
    .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .load(ld_a),
    .load_bcd(lbcd_a), .time_bcd(t_a), .sec_tick(st_a), .wrap(wr_a),
    .zero_hit(zh_a), .load_err(le_a));

  time_counter #(.CLK_HZ(100), .TICK_DIV(TD), .HOURS_EN(1), .HOUR_MAX(12)) u_b (
    .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .load(ld_b),
    .load_bcd(lbcd_b), .time_bcd(t_b), .sec_tick(st_b), .wrap(wr_b),
    .zero_hit(zh_b), .load_err(le_b));

  time_counter #(.CLK_HZ(100), .TICK_DIV(TD), .HOURS_EN(1), .HOUR_MAX(24)) u_c (
    .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .load(ld_c),
    .load_bcd(lbcd_c), .time_bcd(t_c), .sec_tick(st_c), .wrap(wr_c),
    .zero_hit(zh_c), .load_err(le_c));

  typedef struct packed {
    logic [15:0] t;
    logic        st;
    logic        wr;
    logic        zh;
    logic        le;
  } exp_t;

  typedef struct {
    logic        run_v;
    logic        dir_v;
    logic        ld;
    logic [15:0] val;
    int          cycles;
    logic [15:0] exp_time;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_presc, m_secs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic d, input logic l, input logic [15:0] v,
                     input int n, input logic [15:0] e, input string nm);
    vec_t x;
    x.run_v = r; x.dir_v = d; x.ld = l; x.val = v;
    x.cycles = n; x.exp_time = e; x.name = nm;
    vecs.push_back(x);
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Behavioural model of the MM:SS instance, kept in plain seconds.
  task automatic model_cycle(input logic r, input logic d, input logic l, input logic [15:0] v);
    exp_t e;
    e = '0;
    if (l) begin
      m_presc = 0;
      if (v[15:12] <= 5 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9)
        m_secs = (v[15:12] * 10 + v[11:8]) * 60 + v[7:4] * 10 + v[3:0];
      else
        e.le = 1'b1;
    end else if (r && m_presc == TD - 1) begin
      m_presc = 0;
      if (!d) begin
        m_secs = (m_secs + 1) % 3600;
        e.st = 1'b1;
        e.wr = (m_secs == 0);
      end else if (m_secs != 0) begin
        m_secs = m_secs - 1;
        e.st = 1'b1;
        e.zh = (m_secs == 0);
      end
    end else begin
      m_presc = r ? m_presc + 1 : 0;
    end
    e.t = to_bcd(m_secs);
    sb.push_back(e);
  endtask

  task automatic drive_cycle(input logic r, input logic d, input logic l,
                             input logic [15:0] v, input string nm);
    exp_t e, a;
    run = r; dir = d; ld_a = l; lbcd_a = v;
    model_cycle(r, d, l, v);
    @(posedge clk); #1;
    a = {t_a, st_a, wr_a, zh_a, le_a};
    if (sb.size() == 0) begin
      check({nm, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(nm, 32'(a), 32'(e));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; dir = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
    lbcd_a = '0; lbcd_b = '0; lbcd_c = '0;
    m_presc = 0; m_secs = 0;

    //   run dir ld  value     cyc  expected   name
    add(1, 0, 0, 16'h0000,  4, 16'h0001, "first_tick");
    add(1, 0, 0, 16'h0000,  8, 16'h0003, "two_ticks");
    add(1, 0, 1, 16'h5958,  5, 16'h5959, "load_5958");
    add(1, 0, 0, 16'h0000,  4, 16'h0000, "wrap");
    add(1, 1, 1, 16'h0002,  5, 16'h0001, "down_load");
    add(1, 1, 0, 16'h0000,  4, 16'h0000, "zero_hit");
    add(1, 1, 0, 16'h0000,  8, 16'h0000, "hold_zero");
    add(1, 0, 1, 16'h6A00,  1, 16'h0000, "bad_6A00");
    add(1, 0, 1, 16'h1234,  1, 16'h1234, "load_1234");
    add(1, 0, 1, 16'h0075,  1, 16'h1234, "bad_0075");
    add(1, 0, 0, 16'h0000,  3, 16'h1234, "pre_tick");
    add(1, 0, 1, 16'h2000,  1, 16'h2000, "load_on_tick");
    add(1, 0, 0, 16'h0000,  3, 16'h2000, "post_load");
    add(1, 0, 0, 16'h0000,  1, 16'h2001, "post_load_tick");
    add(0, 0, 0, 16'h0000, 10, 16'h2001, "paused");
    add(1, 0, 0, 16'h0000,  3, 16'h2001, "resume");
    add(1, 0, 0, 16'h0000,  1, 16'h2002, "resume_tick");
    add(1, 1, 0, 16'h0000,  4, 16'h2001, "dir_flip");
    add(1, 0, 1, 16'h0959,  1, 16'h0959, "load_0959");
    add(1, 0, 0, 16'h0000,  4, 16'h1000, "min_carry");
    add(1, 1, 0, 16'h0000,  4, 16'h0959, "min_borrow");

    #12;
    check("reset_a", {t_a, st_a, wr_a, zh_a, le_a}, '0);
    check("reset_bc", {t_b, t_c}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        drive_cycle(vecs[i].run_v, vecs[i].dir_v, (c == 0) ? vecs[i].ld : 1'b0,
                    vecs[i].val, $sformatf("%s/c%0d", vecs[i].name, c));
      check({vecs[i].name, "/time"}, 32'(t_a), 32'(vecs[i].exp_time));
    end

    // Asynchronous reset mid-count: A has just pulsed sec_tick.
    reset_n = 1'b0;
    #1;
    check("async_reset_a", {t_a, st_a, wr_a, zh_a, le_a}, '0);
    check("async_reset_bc", {t_b, t_c}, '0);
    step(1);
    reset_n = 1'b1;

    // HH:MM:SS, HOUR_MAX=12: rollover from 11:59:59.
    run = 1'b1; dir = 1'b0; ld_b = 1'b1; lbcd_b = 24'h115959;
    step(1);
    ld_b = 1'b0;
    check("b_load", t_b, 24'h115959);
    step(3);
    check("b_pre_wrap", {t_b, wr_b}, {24'h115959, 1'b0});
    step(1);
    check("b_wrap", {t_b, wr_b, st_b}, {24'h000000, 1'b1, 1'b1});
    step(1);
    check("b_wrap_one_cycle", {wr_b, st_b}, 2'b00);
    ld_b = 1'b1; lbcd_b = 24'h126000;
    step(1);
    ld_b = 1'b0;
    check("b_bad_hour", {t_b, le_b}, {24'h000000, 1'b1});
    step(1);
    check("b_err_one_cycle", le_b, 1'b0);

    // HH:MM:SS, HOUR_MAX=24.
    run = 1'b0; ld_c = 1'b1; lbcd_c = 24'h235959;
    step(1);
    check("c_load", {t_c, le_c}, {24'h235959, 1'b0});
    lbcd_c = 24'h240000;
    step(1);
    ld_c = 1'b0;
    check("c_bad_24", {t_c, le_c}, {24'h235959, 1'b1});
    run = 1'b1;
    step(3);
    check("c_pre_wrap", t_c, 24'h235959);
    step(1);
    check("c_wrap", {t_c, wr_c}, {24'h000000, 1'b1});
    dir = 1'b1;
    step(4);
    check("c_down_at_zero", {t_c, st_c, zh_c}, {24'h000000, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/time_counter.md
# time_counter

Parametrised BCD timekeeper that replaces the fixed MM:SS clock with a single-clock design driven by an internal tick enable; no derived clocks. It counts up as a clock or down as a timer, supports an optional hours field, validates loaded values, and emits tick, wrap and zero events for the display and alarm logic. It sits between the time-setting front end and the 7-segment display driver.

## Interface

- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_DIV, CLK_HZ, clock cycles per one-second tick. Overridden to a small value in simulation; must be ≥ 2.
- HOURS_EN, 0, 0 selects MM:SS (NUM_DIG = 4); 1 selects HH:MM:SS (NUM_DIG = 6).
- HOUR_MAX, 24, hour modulus. Hours count 00 to HOUR_MAX−1. Legal values are 12 and 24.

- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous, active-low reset.
- run, in, 1, 1 lets the prescaler and time advance; 0 holds both.
- dir, in, 1, 0 counts up (clock); 1 counts down (timer).
- load, in, 1, single-cycle request to load load_bcd.
- load_bcd, in, 4*NUM_DIG, BCD digits with the most significant at the top (H1 H0 M1 M0 S1 S0, or M1 M0 S1 S0).
- time_bcd, out, 4*NUM_DIG, current time in the same packing.
- sec_tick, out, 1, one-cycle pulse on each applied one-second step.
- wrap, out, 1, one-cycle pulse when up-count rolls over from max to all-zero.
- zero_hit, out, 1, one-cycle pulse when down-count reaches all-zero.
- load_err, out, 1, one-cycle pulse when a load is rejected.

## Operation

- **Reset:** time_bcd = 0, prescaler = 0. All pulse outputs are 0.
- **Prescaler:** counts 0 to TICK_DIV−1 while run=1. Internal tick is asserted when count = TICK_DIV−1, then the count returns to 0.
  - Prescaler clears to 0 and holds while run=0.
  - Prescaler clears to 0 on any load, accepted or not.
- **Digit limits:**
  - S0 and M0: 0–9. S1 and M1: 0–5.
  - Hours field is a two-digit BCD value 00 to HOUR_MAX−1.
- **Up-count:** increments on tick with a ripple carry S→M→H.
  - At the maximum value (59:59, or (HOUR_MAX−1):59:59), the next tick yields all-zero and pulses wrap.
- **Down-count:** decrements on tick with a ripple borrow.
  - A tick that takes the value to all-zero pulses zero_hit.
  - At all-zero, further down ticks are ignored: value stays zero, no sec_tick, no zero_hit.
- **Load validation:** a load is valid only if every digit is within its limit and hours < HOUR_MAX.
  - Valid load: time_bcd = load_bcd next cycle.
  - Invalid load: time_bcd is unchanged and load_err pulses.
- **Priority:** reset > load > tick. A tick coinciding with load is discarded.
- **dir changes** take effect on the next tick; the current value is never altered.
- **sec_tick** pulses only when the value actually changes on a tick.

## Timing

- All outputs are registered. Pulses assert in the cycle after the causing tick or load and last exactly one cycle.
- time_bcd, sec_tick, wrap and zero_hit all update in the same cycle.
- After run rises, or after a load with run=1, the first tick occurs TICK_DIV cycles later. Steady-state tick period is exactly TICK_DIV cycles.
- Reset assertion clears state immediately, with no clock edge required. Deassertion is synchronised by the system-level reset bridge.
- load is level-sampled each cycle. Holding it high reloads every cycle and suppresses ticks.

## Structure

- Package time_pkg holds:
  - the BCD digit type (4 bits);
  - digit-limit constants (9, 5);
  - the NUM_DIG derivation function;
  - the BCD-valid check function shared with the time-setting front end.
- One sub-module, bcd_mod_counter. It is a two-digit BCD modulo-N counter with:
  - inputs: en, dir, load, load value;
  - outputs: value, carry/borrow out, and an is_zero flag.
- Instantiate it once per field (seconds mod 60, minutes mod 60, hours mod HOUR_MAX), chained through carry/borrow.
- The prescaler and the pulse registers live in time_counter.

## Test plan

- **Prescaler and reset:** TICK_DIV=4, HOURS_EN=0, up, run=1 from reset → time_bcd goes 00:00 → 00:01 after 4 cycles; sec_tick every 4th cycle.
- **Rollover:** load 59:58, up → 59:59, then 00:00 with a single wrap pulse. With HOURS_EN=1, HOUR_MAX=12, load 11:59:59 → 00:00:00 and wrap.
- **Down-count to zero:** load 00:02, dir=1 → 00:01, then 00:00 with zero_hit. Next ticks: value stays 00:00, no sec_tick, no zero_hit.
- **Invalid load:** load 6A:00 or 00:75 → load_err pulse, time unchanged. With HOURS_EN=1, HOUR_MAX=24, load 24:00:00 → load_err.
- **Load vs tick:** load asserted on the tick cycle → loaded value appears and no increment is applied; next tick arrives TICK_DIV cycles later.
- **Pause and reset mid-operation:** run=0 for 10 cycles → value frozen and prescaler cleared. Assert reset_n=0 mid-count → outputs are 0 without a clock edge.
